// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous single-port RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } ram_state_e;

  // Supported read-latency range
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 2;

  function automatic int unsigned nbytes(input int unsigned width);
    return width / 8;
  endfunction

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

endpackage

// File: rtl/sp_ram_core.sv
// Storage array: byte-enabled synchronous write port and a registered read port.
// The array itself is never reset; only the read register is.
module sp_ram_core
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_SIZE = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [nbytes(WIDTH)-1:0]  be_i,
  input  logic                      re_i,
  input  logic                      rzero_i,
  input  logic [ADDR_SIZE-1:0]      addr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  output logic [WIDTH-1:0]          rdata_o
);

  localparam int unsigned NB = nbytes(WIDTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Byte-lane write; callers guarantee addr_i < DEPTH whenever we_i is high
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) begin
          mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Registered read; rzero_i substitutes zero for out-of-range reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_sync_param.sv
// Parametrised synchronous single-port RAM with byte lanes, selectable read
// latency, address-range error pulse and a clear engine that sweeps all words.
module sp_ram_sync_param
  import ram_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter int unsigned      ADDR_SIZE = 3,
  parameter int unsigned      RD_LAT    = 1,
  parameter logic [WIDTH-1:0] CLR_VAL   = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [nbytes(WIDTH)-1:0] be,
  input  logic [ADDR_SIZE-1:0]     addr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_vld,
  output logic                     busy,
  output logic                     addr_err
);

  localparam int unsigned          NB      = nbytes(WIDTH);
  // One extra bit so DEPTH == 2**ADDR_SIZE is representable
  localparam logic [ADDR_SIZE:0]   DepthW  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] LastPtr = ADDR_SIZE'(DEPTH - 1);

  if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
    $error("sp_ram_sync_param: RD_LAT must be 1 or 2");
  end

  ram_state_e             state_q, state_d;
  logic [ADDR_SIZE-1:0]   clr_ptr_q, clr_ptr_d;

  logic                   in_range;
  logic                   user_acc;
  logic                   rd_req;
  logic                   core_we;
  logic [NB-1:0]          core_be;
  logic [ADDR_SIZE-1:0]   core_addr;
  logic [WIDTH-1:0]       core_wdata;
  logic [WIDTH-1:0]       core_rdata;
  logic                   vld1_q;
  logic                   err_q;

  // Next state, sweep pointer and the mux between the sweep and user ports
  always_comb begin
    in_range   = ({1'b0, addr} < DepthW);
    // clr wins over a same-cycle access
    user_acc   = (state_q == StIdle) && en && !clr;
    rd_req     = user_acc && !we;
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    core_we    = 1'b0;
    core_be    = be;
    core_addr  = addr;
    core_wdata = din;
    unique case (state_q)
      StClear: begin
        core_we    = 1'b1;
        core_be    = '1;
        core_addr  = clr_ptr_q;
        core_wdata = CLR_VAL;
        // Compare against DEPTH-1 rather than relying on pointer wrap
        if (clr_ptr_q == LastPtr) begin
          state_d   = StIdle;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      StIdle: begin
        if (clr) begin
          state_d = StClear;
        end else begin
          core_we = en && we && in_range;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // FSM state and sweep pointer; reset starts a full sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  sp_ram_core #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_core (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (core_we),
    .be_i    (core_be),
    .re_i    (rd_req),
    .rzero_i (!in_range),
    .addr_i  (core_addr),
    .wdata_i (core_wdata),
    .rdata_o (core_rdata)
  );

  // First-stage valid and range-error pulses; not gated by state so
  // in-flight reads still complete during a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld1_q <= rd_req;
      err_q  <= user_acc && !in_range;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] dout2_q;
    logic             vld2_q;

    // Extra output stage; holds the last delivered word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout2_q <= '0;
        vld2_q  <= 1'b0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          dout2_q <= core_rdata;
        end
      end
    end

    assign dout     = dout2_q;
    assign dout_vld = vld2_q;
  end else begin : g_lat1
    assign dout     = core_rdata;
    assign dout_vld = vld1_q;
  end

  assign busy     = (state_q == StClear);
  assign addr_err = err_q;

endmodule

// File: tb/tb_sp_ram_sync_param.sv
// Self-checking bench: two instances (DEPTH 8 / RD_LAT 1 and DEPTH 6 / RD_LAT 2)
// compared cycle by cycle against a word-array reference model.
module tb_sp_ram_sync_param;

  localparam logic [15:0] CLR = 16'h0000;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic        clk;
  logic        rst_n_s [2];
  logic        en_s    [2];
  logic        we_s    [2];
  logic        clr_s   [2];
  logic [1:0]  be_s    [2];
  logic [2:0]  addr_s  [2];
  logic [15:0] din_s   [2];
  logic [15:0] dout_s  [2];
  logic        vld_s   [2];
  logic        busy_s  [2];
  logic        err_s   [2];

  logic [15:0] mdl_mem   [2][8];
  logic [15:0] last_dout [2];
  int          busy_left [2];
  int          cyc       [2];
  int          dep       [2];
  int          lat       [2];
  rd_t         pq0[$];
  rd_t         pq1[$];
  int          n_tests;
  int          n_fail;

  sp_ram_sync_param #(
    .WIDTH(16), .DEPTH(8), .ADDR_SIZE(3), .RD_LAT(1), .CLR_VAL(CLR)
  ) dut0 (
    .clk(clk), .rst_n(rst_n_s[0]), .en(en_s[0]), .we(we_s[0]), .be(be_s[0]),
    .addr(addr_s[0]), .din(din_s[0]), .clr(clr_s[0]), .dout(dout_s[0]),
    .dout_vld(vld_s[0]), .busy(busy_s[0]), .addr_err(err_s[0])
  );

  sp_ram_sync_param #(
    .WIDTH(16), .DEPTH(6), .ADDR_SIZE(3), .RD_LAT(2), .CLR_VAL(CLR)
  ) dut1 (
    .clk(clk), .rst_n(rst_n_s[1]), .en(en_s[1]), .we(we_s[1]), .be(be_s[1]),
    .addr(addr_s[1]), .din(din_s[1]), .clr(clr_s[1]), .dout(dout_s[1]),
    .dout_vld(vld_s[1]), .busy(busy_s[1]), .addr_err(err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle(input int d);
    en_s[d] = 1'b0; we_s[d] = 1'b0; clr_s[d] = 1'b0;
    be_s[d] = 2'b00; addr_s[d] = 3'd0; din_s[d] = 16'h0000;
  endtask

  task automatic model_sweep(input int d);
    busy_left[d] = dep[d];
    for (int i = 0; i < 8; i++) mdl_mem[d][i] = CLR;
  endtask

  // Advance one clock: apply the model rules to the current inputs, then
  // compare every output against the model just after the edge.
  task automatic drive_cycle(input int d);
    bit          err_n, rd, have, exp_busy;
    logic [15:0] rdv;
    rd_t         head;
    int          a;
    err_n = 1'b0; rd = 1'b0; have = 1'b0; rdv = 16'h0000;
    a = int'(addr_s[d]);
    if (busy_left[d] > 0) begin
      busy_left[d]--;
    end else if (clr_s[d]) begin
      model_sweep(d);
    end else if (en_s[d]) begin
      if (a >= dep[d]) begin
        err_n = 1'b1;
        if (!we_s[d]) rd = 1'b1;
      end else if (we_s[d]) begin
        for (int k = 0; k < 2; k++)
          if (be_s[d][k]) mdl_mem[d][a][8*k +: 8] = din_s[d][8*k +: 8];
      end else begin
        rd  = 1'b1;
        rdv = mdl_mem[d][a];
      end
    end
    @(posedge clk);
    #1;
    cyc[d]++;
    if (rd) begin
      head.due  = cyc[d] + lat[d] - 1;
      head.data = rdv;
      if (d == 0) pq0.push_back(head);
      else        pq1.push_back(head);
    end
    exp_busy = (busy_left[d] > 0);
    if (d == 0 && pq0.size() > 0) begin
      if (pq0[0].due == cyc[d]) begin have = 1'b1; head = pq0.pop_front(); end
    end else if (d == 1 && pq1.size() > 0) begin
      if (pq1[0].due == cyc[d]) begin have = 1'b1; head = pq1.pop_front(); end
    end
    if (have) last_dout[d] = head.data;
    n_tests++;
    if (busy_s[d] !== exp_busy) begin
      n_fail++;
      $display("FAIL busy[%0d] cyc %0d: got %b want %b", d, cyc[d], busy_s[d], exp_busy);
    end
    n_tests++;
    if (err_s[d] !== err_n) begin
      n_fail++;
      $display("FAIL addr_err[%0d] cyc %0d: got %b want %b", d, cyc[d], err_s[d], err_n);
    end
    n_tests++;
    if (vld_s[d] !== have) begin
      n_fail++;
      $display("FAIL dout_vld[%0d] cyc %0d: got %b want %b", d, cyc[d], vld_s[d], have);
    end
    n_tests++;
    if (dout_s[d] !== last_dout[d]) begin
      n_fail++;
      $display("FAIL dout[%0d] cyc %0d: got %h want %h", d, cyc[d], dout_s[d], last_dout[d]);
    end
  endtask

  task automatic idle_cycles(input int d, input int n);
    set_idle(d);
    repeat (n) drive_cycle(d);
  endtask

  // Assert reset mid-cycle, check outputs at once, release after two edges
  task automatic apply_reset(input int d);
    set_idle(d);
    rst_n_s[d] = 1'b0;
    #1;
    n_tests++;
    if (dout_s[d] !== 16'h0000 || vld_s[d] !== 1'b0 || err_s[d] !== 1'b0 ||
        busy_s[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs[%0d]: got dout=%h vld=%b err=%b busy=%b want 0000 0 0 1",
               d, dout_s[d], vld_s[d], err_s[d], busy_s[d]);
    end
    if (d == 0) pq0.delete();
    else        pq1.delete();
    last_dout[d] = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n_s[d] = 1'b1;
    model_sweep(d);
  endtask

  // Count busy cycles from the current sample point until busy drops
  task automatic count_busy(input int d, input bit random_acc, output int nb);
    int guard;
    nb = busy_s[d] ? 1 : 0;
    guard = 0;
    while (busy_s[d] && guard < 4 * dep[d]) begin
      addr_s[d] = 3'($urandom_range(0, 7));
      if (random_acc) begin
        en_s[d]  = 1'($urandom_range(0, 1));
        we_s[d]  = 1'($urandom_range(0, 1));
        be_s[d]  = 2'($urandom_range(0, 3));
        din_s[d] = 16'($urandom);
        clr_s[d] = ($urandom_range(0, 3) == 0);
      end
      drive_cycle(d);
      guard++;
      if (busy_s[d]) nb++;
    end
  endtask

  task automatic read_all(input int d);
    set_idle(d);
    en_s[d] = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr_s[d] = 3'(a);
      drive_cycle(d);
    end
    idle_cycles(d, 2);
  endtask

  task automatic test_reset(input int d);
    int nb;
    apply_reset(d);
    en_s[d] = 1'b1;
    we_s[d] = 1'b0;
    count_busy(d, 1'b0, nb);
    n_tests++;
    if (nb !== dep[d]) begin
      n_fail++;
      $display("FAIL reset_busy_len[%0d]: got %0d want %0d", d, nb, dep[d]);
    end
    read_all(d);
  endtask

  task automatic test_write_read(input int d);
    set_idle(d);
    en_s[d] = 1'b1; we_s[d] = 1'b1; be_s[d] = 2'b11;
    for (int a = 0; a < dep[d]; a++) begin
      addr_s[d] = 3'(a);
      din_s[d]  = 16'($urandom);
      drive_cycle(d);
    end
    we_s[d] = 1'b0;
    for (int a = 0; a < dep[d]; a++) begin
      addr_s[d] = 3'(a);
      drive_cycle(d);
    end
    idle_cycles(d, 2);
  endtask

  task automatic test_byte_lanes(input int d);
    set_idle(d);
    en_s[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = 3'd3;
    be_s[d] = 2'b11; din_s[d] = 16'hA5A5;
    drive_cycle(d);
    be_s[d] = 2'b01; din_s[d] = 16'h1234;
    drive_cycle(d);
    we_s[d] = 1'b0; be_s[d] = 2'b00;
    drive_cycle(d);
    if (lat[d] == 2) idle_cycles(d, 1);
    n_tests++;
    if (dout_s[d] !== 16'hA534 || vld_s[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_lanes[%0d]: got %h vld=%b want a534 vld=1", d, dout_s[d], vld_s[d]);
    end
    idle_cycles(d, 1);
  endtask

  task automatic test_range(input int d);
    set_idle(d);
    en_s[d] = 1'b1; we_s[d] = 1'b1; be_s[d] = 2'b11; addr_s[d] = 3'd0;
    din_s[d] = 16'hBEEF;
    drive_cycle(d);
    we_s[d] = 1'b0;
    drive_cycle(d);
    idle_cycles(d, 2);
    en_s[d] = 1'b1; we_s[d] = 1'b1; be_s[d] = 2'b11; addr_s[d] = 3'd7;
    din_s[d] = 16'($urandom);
    drive_cycle(d);
    n_tests++;
    if (err_s[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL range_write_err[%0d]: got %b want 1", d, err_s[d]);
    end
    we_s[d] = 1'b0; addr_s[d] = 3'd6;
    drive_cycle(d);
    n_tests++;
    if (err_s[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL range_read_err[%0d]: got %b want 1", d, err_s[d]);
    end
    if (lat[d] == 2) idle_cycles(d, 1);
    n_tests++;
    if (dout_s[d] !== 16'h0000 || vld_s[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL range_read_data[%0d]: got %h vld=%b want 0000 vld=1",
               d, dout_s[d], vld_s[d]);
    end
    read_all(d);
  endtask

  task automatic test_clear(input int d);
    int nb;
    test_write_read(d);
    en_s[d] = 1'b1; we_s[d] = 1'b0; addr_s[d] = 3'd1;
    drive_cycle(d);
    clr_s[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = 3'd2; be_s[d] = 2'b11;
    din_s[d] = 16'hDEAD;
    drive_cycle(d);
    clr_s[d] = 1'b0;
    count_busy(d, 1'b1, nb);
    n_tests++;
    if (nb !== dep[d]) begin
      n_fail++;
      $display("FAIL clear_busy_len[%0d]: got %0d want %0d", d, nb, dep[d]);
    end
    read_all(d);
  endtask

  task automatic test_reset_mid_sweep(input int d);
    int nb;
    test_write_read(d);
    clr_s[d] = 1'b1;
    drive_cycle(d);
    clr_s[d] = 1'b0;
    repeat (4) drive_cycle(d);
    apply_reset(d);
    count_busy(d, 1'b0, nb);
    n_tests++;
    if (nb !== dep[d]) begin
      n_fail++;
      $display("FAIL midreset_busy_len[%0d]: got %0d want %0d", d, nb, dep[d]);
    end
    read_all(d);
  endtask

  task automatic test_random(input int d);
    repeat (300) begin
      clr_s[d]  = ($urandom_range(0, 39) == 0);
      en_s[d]   = ($urandom_range(0, 3) != 0);
      we_s[d]   = 1'($urandom_range(0, 1));
      be_s[d]   = 2'($urandom_range(0, 3));
      addr_s[d] = 3'($urandom_range(0, 7));
      din_s[d]  = 16'($urandom);
      drive_cycle(d);
    end
    idle_cycles(d, dep[d] + 3);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    dep[0] = 8; dep[1] = 6;
    lat[0] = 1; lat[1] = 2;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0;
      busy_left[d] = 0;
      last_dout[d] = 16'h0000;
      rst_n_s[d] = 1'b0;
      set_idle(d);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      test_reset(d);
      test_write_read(d);
      test_byte_lanes(d);
      test_clear(d);
      test_reset_mid_sweep(d);
      test_random(d);
    end
    test_range(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
